st7735r_cmd_sequencer: RTL and testbench

Sits directly upstream of the ST7735R SPI byte serializer. Performs the panel hardware-reset sequence on the RESX pin. Accepts command transactions from the host (one command byte plus N parameter/pixel bytes) and feeds them byte by byte to the serializer. Drives the D/CX pin so each byte is tagged as command or data.

---
 rtl/st7735r_cmd_sequencer.sv | 146 ++++++++++++++
 tb/tb_st7735r_cmd_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st7735r_cmd_sequencer.sv
// ST7735R command sequencer: runs the RESX power-on reset, then streams host
// command/parameter bytes to the SPI serializer one at a time, tagging each via D/CX.
module st7735r_cmd_sequencer #(
  parameter int PARAM_CNT_BITS   = 16,
  parameter int RESX_LOW_CYCLES  = 1000,
  parameter int RESX_WAIT_CYCLES = 120000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sync_reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [7:0]                cmd_byte,
  input  logic [PARAM_CNT_BITS-1:0] cmd_param_count,
  input  logic                      param_valid,
  output logic                      param_ready,
  input  logic [7:0]                param_byte,
  output logic                      ser_data_load,
  output logic [7:0]                ser_data,
  input  logic                      ser_done,
  output logic                      lcd_resx,
  output logic                      lcd_dcx,
  output logic                      busy,
  output logic                      init_done
);

  localparam int MAX_CYC = (RESX_LOW_CYCLES > RESX_WAIT_CYCLES) ? RESX_LOW_CYCLES : RESX_WAIT_CYCLES;
  localparam int DLY_W   = $clog2(MAX_CYC + 1);
  localparam logic [DLY_W-1:0] LOW_LAST  = DLY_W'(RESX_LOW_CYCLES - 1);
  localparam logic [DLY_W-1:0] WAIT_LAST = DLY_W'(RESX_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RESX_LOW,
    S_RESX_WAIT,
    S_IDLE,
    S_CMD_WAIT,
    S_PARAM_FETCH,
    S_PARAM_WAIT
  } state_e;

  state_e                    state_q, state_d;
  logic [DLY_W-1:0]          delay_q, delay_d;
  logic [PARAM_CNT_BITS-1:0] remaining_q, remaining_d;
  logic                      load_q, load_d;
  logic [7:0]                data_q, data_d;
  logic                      dcx_q, dcx_d;
  logic                      resx_q, resx_d;
  logic                      init_done_q, init_done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RESX_LOW;
      delay_q     <= '0;
      remaining_q <= '0;
      load_q      <= 1'b0;
      data_q      <= 8'h00;
      dcx_q       <= 1'b1;
      resx_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else if (sync_reset) begin
      state_q     <= S_RESX_LOW;
      delay_q     <= '0;
      remaining_q <= '0;
      load_q      <= 1'b0;
      data_q      <= 8'h00;
      dcx_q       <= 1'b1;
      resx_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      remaining_q <= remaining_d;
      load_q      <= load_d;
      data_q      <= data_d;
      dcx_q       <= dcx_d;
      resx_q      <= resx_d;
      init_done_q <= init_done_d;
    end
  end

  // Byte, D/CX and load strobe are all captured together so the serializer sees them aligned.
  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    remaining_d = remaining_q;
    load_d      = 1'b0;
    data_d      = data_q;
    dcx_d       = dcx_q;
    resx_d      = resx_q;
    init_done_d = init_done_q;
    case (state_q)
      S_RESX_LOW: begin
        if (delay_q == LOW_LAST) begin
          state_d = S_RESX_WAIT;
          delay_d = '0;
          resx_d  = 1'b1;
        end else begin
          delay_d = delay_q + DLY_W'(1);
        end
      end
      S_RESX_WAIT: begin
        if (delay_q == WAIT_LAST) begin
          state_d     = S_IDLE;
          delay_d     = '0;
          init_done_d = 1'b1;
        end else begin
          delay_d = delay_q + DLY_W'(1);
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          data_d      = cmd_byte;
          dcx_d       = 1'b0;
          load_d      = 1'b1;
          remaining_d = cmd_param_count;
          state_d     = S_CMD_WAIT;
        end
      end
      S_CMD_WAIT, S_PARAM_WAIT: begin
        if (ser_done) begin
          state_d = (remaining_q == '0) ? S_IDLE : S_PARAM_FETCH;
        end
      end
      S_PARAM_FETCH: begin
        if (param_valid) begin
          data_d      = param_byte;
          dcx_d       = 1'b1;
          load_d      = 1'b1;
          remaining_d = remaining_q - PARAM_CNT_BITS'(1);
          state_d     = S_PARAM_WAIT;
        end
      end
      default: state_d = S_RESX_LOW;
    endcase
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign param_ready   = (state_q == S_PARAM_FETCH);
  assign busy          = (state_q != S_IDLE);
  assign ser_data_load = load_q;
  assign ser_data      = data_q;
  assign lcd_dcx       = dcx_q;
  assign lcd_resx      = resx_q;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_st7735r_cmd_sequencer.sv
// Bench for st7735r_cmd_sequencer: expected byte-stream model plus a serializer
// model with configurable ser_done latency.
module tb_st7735r_cmd_sequencer;

  localparam int PCB   = 7;
  localparam int LOWC  = 4;
  localparam int WAITC = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           sync_reset = 1'b0;
  logic           cmd_valid = 1'b0;
  logic [7:0]     cmd_byte = 8'h00;
  logic [PCB-1:0] cmd_param_count = '0;
  logic           param_valid = 1'b0;
  logic [7:0]     param_byte = 8'h00;
  logic           serDoneModel = 1'b0;
  logic           spuriousDone = 1'b0;
  logic           ser_done;
  logic           cmd_ready, param_ready, ser_data_load, lcd_resx, lcd_dcx, busy, init_done;
  logic [7:0]     ser_data;

  assign ser_done = serDoneModel | spuriousDone;

  always #5 clk = ~clk;

  st7735r_cmd_sequencer #(
    .PARAM_CNT_BITS(PCB),
    .RESX_LOW_CYCLES(LOWC),
    .RESX_WAIT_CYCLES(WAITC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sync_reset(sync_reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_byte(cmd_byte),
    .cmd_param_count(cmd_param_count),
    .param_valid(param_valid),
    .param_ready(param_ready),
    .param_byte(param_byte),
    .ser_data_load(ser_data_load),
    .ser_data(ser_data),
    .ser_done(ser_done),
    .lcd_resx(lcd_resx),
    .lcd_dcx(lcd_dcx),
    .busy(busy),
    .init_done(init_done)
  );

  typedef struct {
    logic [7:0] data;
    logic       dcx;
    int         cnt;
  } load_t;

  load_t      expQ[$];
  logic [7:0] hostParams[$];
  int         checks = 0;
  int         errors = 0;
  bit         checkEn = 1'b0;
  int         loadCount = 0;
  logic [7:0] lastLoadData = 8'h00;
  int         serLatMin = 3;
  int         serLatMax = 3;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Serializer: answers every load with one ser_done pulse after a random latency.
  initial begin : serModel
    int  cnt;
    bit  outst;
    cnt   = 0;
    outst = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n || sync_reset) begin
        outst        = 1'b0;
        serDoneModel = 1'b0;
      end else if (ser_data_load) begin
        outst        = 1'b1;
        cnt          = $urandom_range(serLatMax, serLatMin);
        serDoneModel = 1'b0;
      end else if (outst) begin
        cnt--;
        if (cnt == 0) begin
          serDoneModel = 1'b1;
          outst        = 1'b0;
        end else begin
          serDoneModel = 1'b0;
        end
      end else begin
        serDoneModel = 1'b0;
      end
    end
  end

  // Per-cycle compare against the expected byte stream and the handshake/serializer rules.
  initial begin : compare
    bit    outst;
    bit    hsPending;
    bit    doneSeen;
    int    rem;
    logic  lastDcx;
    load_t e;
    outst = 0; hsPending = 0; doneSeen = 0; rem = 0; lastDcx = 1'b1;
    forever begin
      @(negedge clk);
      if (!checkEn) begin
        outst = 0; hsPending = 0; doneSeen = 0; rem = 0; lastDcx = 1'b1;
      end else begin
        checkOutput("load_timing", ser_data_load, hsPending);
        if (ser_data_load) begin
          loadCount++;
          lastLoadData = ser_data;
          checkOutput("load_overlap", outst, 0);
          checks++;
          if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_load: got data 0x%0h, expected no load", ser_data);
            lastDcx = lcd_dcx;
          end else begin
            e = expQ.pop_front();
            checkOutput("ser_data", ser_data, e.data);
            checkOutput("load_dcx", lcd_dcx, e.dcx);
            if (e.dcx == 1'b0) rem = e.cnt;
            else rem--;
            lastDcx = e.dcx;
          end
          outst = 1'b1;
        end else begin
          checkOutput("dcx_hold", lcd_dcx, lastDcx);
        end
        if (outst) begin
          checkOutput("cmd_ready_in_wait", cmd_ready, 0);
          checkOutput("param_ready_in_wait", param_ready, 0);
        end
        if (doneSeen) begin
          checkOutput("cmd_ready_after_done", cmd_ready, rem == 0);
          checkOutput("param_ready_after_done", param_ready, rem != 0);
        end
        doneSeen = 0;
        if (ser_done && outst) begin
          outst    = 0;
          doneSeen = 1;
        end
        checkOutput("ready_exclusive", cmd_ready & param_ready, 0);
        checkOutput("busy_vs_idle", busy, !cmd_ready);
        hsPending = (cmd_valid && cmd_ready) || (param_valid && param_ready);
      end
    end
  end

  task automatic waitHandshake(input bit isCmd);
    int n;
    bit got;
    n   = 0;
    got = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (isCmd ? cmd_ready : param_ready) got = 1;
    end
    checkOutput(isCmd ? "cmd_handshake_timeout" : "param_handshake_timeout", got, 1);
    @(posedge clk);
    #1;
  endtask

  // Sends one command; sends nSend of its params (stalling before stallIdx) and,
  // if aborted early, leaves param_valid asserted on the next byte.
  task automatic applyStimulus(input logic [7:0] cmd, input int count, input int nSend,
                               input int stallIdx, input int stallCycles);
    load_t e;
    e.data = cmd; e.dcx = 1'b0; e.cnt = count;
    expQ.push_back(e);
    for (int i = 0; i < count; i++) begin
      e.data = hostParams[i]; e.dcx = 1'b1; e.cnt = 0;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_byte        = cmd;
    cmd_param_count = PCB'(count);
    cmd_valid       = 1'b1;
    waitHandshake(1'b1);
    cmd_valid = 1'b0;
    for (int i = 0; i < nSend; i++) begin
      if (i == stallIdx) begin
        repeat (stallCycles) @(posedge clk);
        #1;
      end
      param_byte  = hostParams[i];
      param_valid = 1'b1;
      waitHandshake(1'b0);
      param_valid = 1'b0;
    end
    if (nSend < count) begin
      param_byte  = hostParams[nSend];
      param_valid = 1'b1;
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (n < 5000 && !(busy == 1'b0 && expQ.size() == 0)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", n < 5000, 1);
  endtask

  task automatic initSequence(input bit useSync);
    checkEn = 1'b0;
    expQ.delete();
    @(posedge clk);
    #1;
    if (useSync) sync_reset = 1'b1;
    else reset_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_resx", lcd_resx, 0);
    checkOutput("rst_dcx", lcd_dcx, 1);
    checkOutput("rst_load", ser_data_load, 0);
    checkOutput("rst_data", ser_data, 8'h00);
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_init_done", init_done, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_param_ready", param_ready, 0);
    sync_reset = 1'b0;
    reset_n    = 1'b1;
    for (int i = 0; i < LOWC; i++) begin
      @(negedge clk);
      checkOutput("low_resx", lcd_resx, 0);
      checkOutput("low_busy", busy, 1);
      checkOutput("low_cmd_ready", cmd_ready, 0);
      checkOutput("low_init_done", init_done, 0);
      checkOutput("low_load", ser_data_load, 0);
      checkOutput("low_param_ready", param_ready, 0);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < WAITC; i++) begin
      @(negedge clk);
      checkOutput("wait_resx", lcd_resx, 1);
      checkOutput("wait_busy", busy, 1);
      checkOutput("wait_cmd_ready", cmd_ready, 0);
      checkOutput("wait_init_done", init_done, 0);
      checkOutput("wait_load", ser_data_load, 0);
    end
    @(negedge clk);
    checkOutput("ready_cmd_ready", cmd_ready, 1);
    checkOutput("ready_init_done", init_done, 1);
    checkOutput("ready_busy", busy, 0);
    checkOutput("ready_resx", lcd_resx, 1);
    checkOutput("ready_dcx", lcd_dcx, 1);
    checkEn = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int base;
    int n;

    // Power-on reset with host requests held high during the reset states.
    cmd_valid   = 1'b1;
    cmd_byte    = 8'hA5;
    param_valid = 1'b1;
    param_byte  = 8'hEE;
    initSequence(1'b0);

    // SWRESET, no parameters; param_valid stays high and must be ignored.
    hostParams.delete();
    base = loadCount;
    applyStimulus(8'h01, 0, 0, -1, 0);
    waitIdle();
    checkOutput("swreset_loads", loadCount - base, 1);
    checkOutput("swreset_byte", lastLoadData, 8'h01);
    @(negedge clk);
    checkOutput("swreset_idle", cmd_ready, 1);
    param_valid = 1'b0;

    // CASET with a 10-cycle host stall before the third parameter.
    hostParams = {8'h00, 8'h00, 8'h00, 8'h7F};
    base = loadCount;
    applyStimulus(8'h2A, 4, 4, 2, 10);
    waitIdle();
    checkOutput("caset_loads", loadCount - base, 5);
    checkOutput("caset_last", lastLoadData, 8'h7F);

    // Spurious ser_done while idle.
    @(posedge clk); #1; spuriousDone = 1'b1;
    @(posedge clk); #1; spuriousDone = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("spur_idle_ready", cmd_ready, 1);
      checkOutput("spur_idle_load", ser_data_load, 0);
    end

    // Spurious ser_done while waiting for a parameter byte.
    hostParams = {8'h36};
    base = loadCount;
    fork
      applyStimulus(8'h36, 1, 1, 0, 20);
      begin
        n = 0;
        while (!param_ready && n < 100) begin
          @(negedge clk);
          n++;
        end
        checkOutput("spur_reach_fetch", param_ready, 1);
        @(posedge clk); #1; spuriousDone = 1'b1;
        @(posedge clk); #1; spuriousDone = 1'b0;
        @(negedge clk);
        checkOutput("spur_fetch_ready", param_ready, 1);
        checkOutput("spur_fetch_load", ser_data_load, 0);
      end
    join
    waitIdle();
    checkOutput("madctl_loads", loadCount - base, 2);
    checkOutput("madctl_last", lastLoadData, 8'h36);

    // 64-byte RAMWR burst with random serializer latency.
    serLatMin = 5;
    serLatMax = 40;
    hostParams.delete();
    for (int i = 0; i < 64; i++) hostParams.push_back(8'($urandom));
    base = loadCount;
    applyStimulus(8'h2C, 64, 64, -1, 0);
    waitIdle();
    checkOutput("burst_loads", loadCount - base, 65);
    serLatMin = 3;
    serLatMax = 3;

    // All-ones parameter count must drain exactly to zero.
    hostParams.delete();
    for (int i = 0; i < 127; i++) hostParams.push_back(8'(i));
    base = loadCount;
    applyStimulus(8'h2C, 127, 127, -1, 0);
    waitIdle();
    checkOutput("allones_loads", loadCount - base, 128);
    checkOutput("allones_last", lastLoadData, 8'h7E);

    // sync_reset after 2 of 4 parameters; pending param_valid must be ignored afterwards.
    hostParams = {8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(8'h2A, 4, 2, -1, 0);
    initSequence(1'b1);
    repeat (6) begin
      @(negedge clk);
      checkOutput("abort_param_ready", param_ready, 0);
      checkOutput("abort_load", ser_data_load, 0);
    end
    param_valid = 1'b0;
    hostParams = {8'h5A};
    base = loadCount;
    applyStimulus(8'h3A, 1, 1, -1, 0);
    waitIdle();
    checkOutput("post_abort_loads", loadCount - base, 2);
    checkOutput("post_abort_last", lastLoadData, 8'h5A);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
